apb_host_bridge: RTL and testbench

//  APB initiator (requester) that converts a valid/ready command channel from the host side into APB

---
 rtl/apb_host_bridge_if.sv | 40 ++++
 rtl/apb_host_bridge.sv | 123 ++++++++++++
 tb/tb_apb_host_bridge.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_host_bridge_if.sv
// Host command/response channels plus the APB initiator signals of the bridge.
// The master modport is the bridge's view; slave is the environment's view
// (host and peripheral cluster together).
interface apb_host_bridge_if #(
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              PSEL;
  logic              PENABLE;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_host_bridge.sv
// APB initiator: turns one host valid/ready command into an APB SETUP/ACCESS
// transfer and returns read data / error on a valid/ready response channel.
// Only one transfer is ever outstanding.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | ready for a command; accept latches address/direction/data
//   S_SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
//   S_ACCESS | PSEL=1, PENABLE=1 until PREADY or the wait-state timeout
//   S_RESP   | response held on rsp_* until the host takes it
module apb_host_bridge #(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 16
) (
  input logic              PCLK,
  input logic              PRESETn,
  apb_host_bridge_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  // A zero TIMEOUT still needs a 1-bit counter so the declarations stay legal.
  localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(LAST_I);
  localparam logic [WCNT_W-1:0] WCNT_MAX  = '1;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic              accept;
  logic              timeout_hit;
  logic              unused_addr_lsb;

  // Word-aligned bus: the byte offset bits of the host address are dropped.
  assign unused_addr_lsb = ^bus.req_addr[1:0];

  assign accept = (state_q == S_IDLE) && bus.req_valid;

  // The current ACCESS cycle is the last one allowed if PREADY stays low;
  // PREADY arriving in that same cycle still wins as a normal completion.
  assign timeout_hit = (TIMEOUT != 0) && (wcnt_q == WCNT_LAST);

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state and state-decoded handshake/APB control outputs.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.PSEL      = 1'b0;
    bus.PENABLE   = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = S_SETUP;
      end
      S_SETUP: begin
        bus.PSEL = 1'b1;
        state_d  = S_ACCESS;
      end
      S_ACCESS: begin
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        if (bus.PREADY || timeout_hit) state_d = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address/direction/data captured on accept and held until the next accept.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bus.PADDR  <= '0;
      bus.PWRITE <= 1'b0;
      bus.PWDATA <= '0;
    end else if (accept) begin
      bus.PADDR  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
      bus.PWRITE <= bus.req_write;
      bus.PWDATA <= bus.req_write ? bus.req_wdata : 32'h0;
    end
  end

  // Response capture at the end of ACCESS; held stable through RESP.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (state_q == S_ACCESS) begin
      if (bus.PREADY) begin
        bus.rsp_rdata <= bus.PWRITE ? 32'h0 : bus.PRDATA;
        bus.rsp_err   <= bus.PSLVERR;
      end else if (timeout_hit) begin
        bus.rsp_rdata <= 32'h0;
        bus.rsp_err   <= 1'b1;
      end
    end
  end

  // Saturating wait-state counter, cleared when the response is taken.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wcnt_q <= '0;
    end else if (state_q == S_RESP && bus.rsp_ready) begin
      wcnt_q <= '0;
    end else if (state_q == S_ACCESS && !bus.PREADY && wcnt_q != WCNT_MAX) begin
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_host_bridge.sv
// Directed bench for apb_host_bridge: write, read, wait states, timeout,
// slave error, response backpressure and reset during ACCESS.
module tb_apb_host_bridge;

  logic PCLK;
  logic PRESETn;
  int   checks;
  int   errors;

  apb_host_bridge_if #(.ADDR_W(7)) bus ();

  apb_host_bridge #(.ADDR_W(7), .TIMEOUT(16)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic w, input logic [6:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    #12;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready act=%0h exp=1", bus.req_ready); end
    checks++; if (bus.PSEL !== 1'b0) begin errors++; $display("FAIL rst_psel act=%0h exp=0", bus.PSEL); end
    checks++; if (bus.PENABLE !== 1'b0) begin errors++; $display("FAIL rst_penable act=%0h exp=0", bus.PENABLE); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid act=%0h exp=0", bus.rsp_valid); end
    checks++; if (bus.PADDR !== 7'h00) begin errors++; $display("FAIL rst_paddr act=%0h exp=0", bus.PADDR); end
    checks++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp act=%0h/%0h exp=0/0", bus.rsp_rdata, bus.rsp_err); end
    tick();
    PRESETn = 1'b1;
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_rel_req_ready act=%0h exp=1", bus.req_ready); end
  endtask

  task automatic test_write();
    bus.PREADY = 1'b1;
    issue(1'b1, 7'h14, 32'hA5A5_0001);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL wr_c0_req_ready act=%0h exp=1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0) begin errors++; $display("FAIL wr_c1_setup act=%0h%0h exp=10", bus.PSEL, bus.PENABLE); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL wr_c1_req_ready act=%0h exp=0", bus.req_ready); end
    tick();
    checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin errors++; $display("FAIL wr_c2_access act=%0h%0h exp=11", bus.PSEL, bus.PENABLE); end
    checks++; if (bus.PADDR !== 7'h14 || bus.PWRITE !== 1'b1) begin errors++; $display("FAIL wr_c2_addr act=%0h/%0h exp=14/1", bus.PADDR, bus.PWRITE); end
    checks++; if (bus.PWDATA !== 32'hA5A5_0001) begin errors++; $display("FAIL wr_c2_pwdata act=%0h exp=a5a50001", bus.PWDATA); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_c2_rsp_valid act=%0h exp=0", bus.rsp_valid); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.PSEL !== 1'b0) begin errors++; $display("FAIL wr_c3_resp act=%0h/%0h exp=1/0", bus.rsp_valid, bus.PSEL); end
    checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_c3_data act=%0h/%0h exp=0/0", bus.rsp_err, bus.rsp_rdata); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL wr_c4_idle act=%0h/%0h exp=0/1", bus.rsp_valid, bus.req_ready); end
  endtask

  task automatic test_read();
    bus.PRDATA = 32'h0000_1234;
    issue(1'b0, 7'h27, 32'hFFFF_FFFF);
    tick();
    bus.req_valid = 1'b0;
    tick();
    checks++; if (bus.PADDR !== 7'h24 || bus.PWRITE !== 1'b0) begin errors++; $display("FAIL rd_addr act=%0h/%0h exp=24/0", bus.PADDR, bus.PWRITE); end
    checks++; if (bus.PWDATA !== 32'h0) begin errors++; $display("FAIL rd_pwdata act=%0h exp=0", bus.PWDATA); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0000_1234 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rd_rsp act=%0h/%0h/%0h exp=1/1234/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
    tick();
  endtask

  task automatic test_wait_states();
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'hDEAD_BEEF;
    issue(1'b0, 7'h30, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.PENABLE !== 1'b1 || bus.PADDR !== 7'h30) begin errors++; $display("FAIL ws_access%0d act=%0h/%0h exp=1/30", k, bus.PENABLE, bus.PADDR); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL ws_rsp_early%0d act=%0h exp=0", k, bus.rsp_valid); end
      if (k == 3) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b0;
      end
    end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.PENABLE !== 1'b0) begin errors++; $display("FAIL ws_resp act=%0h/%0h exp=1/0", bus.rsp_valid, bus.PENABLE); end
    checks++; if (bus.rsp_rdata !== 32'hDEAD_BEEF || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL ws_data act=%0h/%0h exp=deadbeef/0", bus.rsp_rdata, bus.rsp_err); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h7777_7777;
    issue(1'b0, 7'h3C, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.rsp_valid) break;
      if (bus.PENABLE) n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL to_access_cycles act=%0d exp=16", n); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.PSEL !== 1'b0) begin errors++; $display("FAIL to_resp act=%0h/%0h exp=1/0", bus.rsp_valid, bus.PSEL); end
    checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_data act=%0h/%0h exp=1/0", bus.rsp_err, bus.rsp_rdata); end
    bus.PREADY = 1'b1;
    tick();
  endtask

  task automatic test_timeout_edge();
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h0BAD_F00D;
    issue(1'b0, 7'h04, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 16) begin
        checks++; if (bus.PENABLE !== 1'b1) begin errors++; $display("FAIL toe_access16 act=%0h exp=1", bus.PENABLE); end
        bus.PREADY = 1'b1;
      end
    end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL toe_rsp act=%0h/%0h/%0h exp=1/0/badf00d", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    tick();
  endtask

  task automatic test_slverr();
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    issue(1'b1, 7'h08, 32'h0000_0001);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL slverr_rsp act=%0h/%0h/%0h exp=1/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    bus.PSLVERR = 1'b0;
    tick();
  endtask

  task automatic test_back_pressure();
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = 32'h5555_AAAA;
    issue(1'b0, 7'h18, 32'h0);
    tick();
    issue(1'b1, 7'h0C, 32'h0000_C0DE);
    tick();
    tick();
    bus.PRDATA = 32'h0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL bp_hold%0d act=%0h/%0h exp=1/5555aaaa", k, bus.rsp_valid, bus.rsp_rdata); end
      checks++; if (bus.req_ready !== 1'b0 || bus.PSEL !== 1'b0) begin errors++; $display("FAIL bp_block%0d act=%0h/%0h exp=0/0", k, bus.req_ready, bus.PSEL); end
      tick();
    end
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid act=%0h exp=1", bus.rsp_valid); end
    bus.rsp_ready = 1'b1;
    tick();
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) begin errors++; $display("FAIL bp_idle act=%0h/%0h/%0h exp=1/0/0", bus.req_ready, bus.rsp_valid, bus.PSEL); end
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.PSEL !== 1'b1 || bus.PADDR !== 7'h0C || bus.PWRITE !== 1'b1 || bus.PWDATA !== 32'h0000_C0DE) begin errors++; $display("FAIL bp_second act=%0h/%0h/%0h/%0h exp=1/c/1/c0de", bus.PSEL, bus.PADDR, bus.PWRITE, bus.PWDATA); end
    tick();
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL bp_second_rsp act=%0h/%0h/%0h exp=1/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.PREADY = 1'b0;
    issue(1'b0, 7'h2C, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    checks++; if (bus.PENABLE !== 1'b1) begin errors++; $display("FAIL rm_in_access act=%0h exp=1", bus.PENABLE); end
    PRESETn = 1'b0;
    #1;
    checks++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_drop act=%0h/%0h/%0h exp=0/0/0", bus.PSEL, bus.PENABLE, bus.rsp_valid); end
    checks++; if (bus.req_ready !== 1'b1 || bus.PADDR !== 7'h00) begin errors++; $display("FAIL rm_idle act=%0h/%0h exp=1/0", bus.req_ready, bus.PADDR); end
    #1;
    PRESETn = 1'b1;
    tick();
    checks++; if (bus.req_ready !== 1'b1 || bus.PSEL !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_after act=%0h/%0h/%0h exp=1/0/0", bus.req_ready, bus.PSEL, bus.rsp_valid); end
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hCAFE_0042;
    issue(1'b0, 7'h10, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    checks++; if (bus.PADDR !== 7'h10 || bus.PENABLE !== 1'b1) begin errors++; $display("FAIL rm_fresh_access act=%0h/%0h exp=10/1", bus.PADDR, bus.PENABLE); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hCAFE_0042 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rm_fresh_rsp act=%0h/%0h/%0h exp=1/cafe0042/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
    tick();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    PRESETn       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;

    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_timeout();
    test_timeout_edge();
    test_slverr();
    test_back_pressure();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
